// File: rtl/div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_hilo_ctrl
// Description : Control stage in front of a combinational unsigned restoring
//               divider core. It captures one divide request, drives operand
//               magnitudes to the core, holds them for CORE_LAT cycles,
//               sign-corrects the core's {remainder, quotient} and writes the
//               HI (remainder) / LO (quotient) register pair. A zero divisor
//               is resolved locally without waiting on the core.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH     operand width; the core result is 2*WIDTH bits
//   CORE_LAT  cycles the core inputs are held before sampling (1..15)
// Ports:
//   clk          system clock, rising-edge
//   reset_n      asynchronous active-low reset
//   start        request strobe, sampled only while idle
//   signed_op    1 = signed two's-complement divide, 0 = unsigned
//   RegA / RegB  dividend / divisor, valid on the accepting edge only
//   core_a/b     dividend / divisor magnitudes driven to the core
//   core_z       core result {remainder, quotient}, unsigned
//   busy         request in flight (registered)
//   done         one-cycle pulse when HI/LO are written
//   div_by_zero  status of the last completed request
//   HI / LO      remainder / quotient registers
// ============================================================================
module div_hilo_ctrl #(
  parameter int WIDTH    = 32,
  parameter int CORE_LAT = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   RegA,
  input  logic [WIDTH-1:0]   RegB,
  output logic [WIDTH-1:0]   core_a,
  output logic [WIDTH-1:0]   core_b,
  input  logic [2*WIDTH-1:0] core_z,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO
);

  // Counter is sized for the full legal CORE_LAT range (1..15).
  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               qneg;     // quotient must be negated
  logic               rneg;     // remainder must be negated (follows dividend)
  logic [WIDTH-1:0]   zero_hi;  // raw dividend, reported in HI on divide-by-zero

  // --------------------------------------------------------------------------
  // Operand conditioning (evaluated on the accepting edge only).
  // Negating the most negative value wraps back to itself, which read as an
  // unsigned magnitude is exactly right, so no special case is needed.
  // --------------------------------------------------------------------------
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_is_zero;

  assign a_neg     = signed_op & RegA[WIDTH-1];
  assign b_neg     = signed_op & RegB[WIDTH-1];
  assign a_mag     = a_neg ? (-RegA) : RegA;
  assign b_mag     = b_neg ? (-RegB) : RegB;
  assign b_is_zero = (RegB == '0);

  // --------------------------------------------------------------------------
  // Result sign correction. The core path is a CORE_LAT-cycle multicycle
  // path: core_a/core_b are stable from the accepting edge until core_z is
  // sampled on the completing edge.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] hi_next;

  assign quo     = core_z[WIDTH-1:0];
  assign rem     = core_z[2*WIDTH-1:WIDTH];
  assign lo_next = qneg ? (-quo) : quo;
  assign hi_next = rneg ? (-rem) : rem;

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs. done defaults low every cycle so it
  // is a single-cycle pulse; the done cycle is IDLE, so a new request can be
  // accepted in it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      zero_hi     <= '0;
      core_a      <= '0;
      core_b      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            core_a  <= a_mag;
            core_b  <= b_mag;
            qneg    <= a_neg ^ b_neg;
            rneg    <= a_neg;
            zero_hi <= RegA;
            busy    <= 1'b1;
            if (b_is_zero) begin
              state <= S_ZERO;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end

        S_WAIT: begin
          if (cnt == '0) begin
            LO          <= lo_next;
            HI          <= hi_next;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_ZERO: begin
          // Core output is irrelevant here; report all-ones quotient and the
          // untouched dividend as remainder.
          LO          <= '1;
          HI          <= zero_hi;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_hilo_ctrl
// Description : Self-checking bench for div_hilo_ctrl. Includes a behavioural
//               model of the unsigned divider core, a table of directed
//               vectors, hand-written multi-cycle sequences (reset mid-flight,
//               ignored start, back-to-back) and randomized requests checked
//               against a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_hilo_ctrl;

  localparam int W        = 32;
  localparam int CORE_LAT = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic           signed_op;
  logic [W-1:0]   RegA;
  logic [W-1:0]   RegB;
  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic [2*W-1:0] core_z;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [W-1:0]   HI;
  logic [W-1:0]   LO;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_hilo_ctrl #(.WIDTH(W), .CORE_LAT(CORE_LAT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .signed_op   (signed_op),
    .RegA        (RegA),
    .RegB        (RegB),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_z      (core_z),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  // Unsigned combinational divider core model.
  always_comb begin
    core_z = '0;
    if (core_b != '0) core_z = {core_a % core_b, core_a / core_b};
  end

  typedef struct packed {
    logic         sop;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: truncating division evaluated in 64-bit arithmetic so the
  // most-negative / -1 case needs no special handling; result taken mod 2^W.
  function automatic void ref_div(input logic sop, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] lo,
                                  output logic [W-1:0] hi, output logic dbz);
    longint sa, sb, q, r;
    if (b == '0) begin
      lo = '1; hi = a; dbz = 1'b1;
    end else begin
      sa = sop ? longint'($signed(a)) : longint'(a);
      sb = sop ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
      dbz = 1'b0;
    end
  endfunction

  // Called at a negedge while idle; returns at the negedge after the
  // accepting edge, with inputs scrambled to prove they were latched.
  task automatic issue(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b);
    signed_op = sop; RegA = a; RegB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; signed_op = 1'($urandom); RegA = $urandom; RegB = $urandom;
  endtask

  // Counts completing edges after the accepting edge until done is seen.
  task automatic await_done(input int exp_lat, input string name);
    int lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      chk({name, " busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_req(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic edbz, input string name);
    issue(sop, a, b);
    await_done((b == '0) ? 1 : CORE_LAT, name);
    chk({name, " LO"}, 64'(LO), 64'(elo));
    chk({name, " HI"}, 64'(HI), 64'(ehi));
    chk({name, " dbz"}, 64'(div_by_zero), 64'(edbz));
    chk({name, " busy@done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({name, " done width"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] elo, ehi, ra, rb;
    logic         edbz, rs;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3] = '{1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
    vecs[4] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[5] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
    vecs[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0};
    vecs[8] = '{1'b1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};

    // Reset state
    reset_n = 1'b0; start = 1'b0; signed_op = 1'b0; RegA = '0; RegB = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst dbz",  64'(div_by_zero), 64'd0);
    chk("rst HI",   64'(HI), 64'd0);
    chk("rst LO",   64'(LO), 64'd0);
    chk("rst core_a", 64'(core_a), 64'd0);
    chk("rst core_b", 64'(core_b), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].sop, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi,
              vecs[i].dbz, $sformatf("vec%0d", i));
    end

    // Core operands are magnitudes and stay stable through the settle window
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("mag core_a c0", 64'(core_a), 64'd7);
    chk("mag core_b c0", 64'(core_b), 64'd2);
    @(negedge clk);
    chk("mag core_a c1", 64'(core_a), 64'd7);
    chk("mag core_b c1", 64'(core_b), 64'd2);
    @(negedge clk);
    chk("mag done", 64'(done), 64'd1);
    chk("mag LO", 64'(LO), 64'hFFFF_FFFD);
    chk("mag HI", 64'(HI), 64'hFFFF_FFFF);
    @(negedge clk);

    // Back-to-back: second start raised in the first done cycle
    issue(1'b0, 32'd50, 32'd5);
    await_done(CORE_LAT, "b2b first");
    chk("b2b first LO", 64'(LO), 64'd10);
    chk("b2b first HI", 64'(HI), 64'd0);
    signed_op = 1'b0; RegA = 32'd17; RegB = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; RegA = $urandom; RegB = $urandom;
    chk("b2b first done width", 64'(done), 64'd0);
    chk("b2b second accepted", 64'(busy), 64'd1);
    await_done(CORE_LAT, "b2b second");
    chk("b2b second LO", 64'(LO), 64'd4);
    chk("b2b second HI", 64'(HI), 64'd1);
    @(negedge clk);
    chk("b2b second done width", 64'(done), 64'd0);

    // Asynchronous reset in the middle of WAIT
    issue(1'b0, 32'd100, 32'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst HI", 64'(HI), 64'd0);
    chk("arst LO", 64'(LO), 64'd0);
    chk("arst core_a", 64'(core_a), 64'd0);
    chk("arst core_b", 64'(core_b), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("arst no done", 64'(done), 64'd0);
    end

    // start held while busy is ignored
    issue(1'b0, 32'd50, 32'd5);
    start = 1'b1; RegA = 32'd1; RegB = 32'd1;
    @(negedge clk);
    chk("ign busy", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk("ign done", 64'(done), 64'd1);
    chk("ign LO", 64'(LO), 64'd10);
    chk("ign HI", 64'(HI), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ign idle busy", 64'(busy), 64'd0);
      chk("ign LO held", 64'(LO), 64'd10);
    end

    // Randomized requests against the reference model
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = -32'($urandom_range(1, 20));
        4:       ra = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if (ra == 32'h8000_0000) rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
      ref_div(rs, ra, rb, elo, ehi, edbz);
      run_req(rs, ra, rb, elo, ehi, edbz, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
